// File: rtl/wordcount_pkg.sv
// Shared widths and the accum write record for the accum_array write path.
// Pure definitions: no latency, no flow control.
package wordcount_pkg;
  localparam int ACCUM_ADDR_W = 32;
  localparam int ACCUM_DATA_W = 64;
  localparam int COALESCE_MAX = 16;

  typedef struct packed {
    logic [ACCUM_ADDR_W-1:0] addr;
    logic [ACCUM_DATA_W-1:0] din;
  } accum_wr_t;
endpackage

// File: rtl/accum_lane_fifo.sv
// Per-lane synchronous FIFO of accum writes; head is visible the cycle after the push.
// Pushes while full are ignored (caller flags the drop); pops while empty are ignored.
module accum_lane_fifo
  import wordcount_pkg::*;
#(
  parameter int DEPTH            = 16,
  parameter int PROG_FULL_MARGIN = 4,
  localparam int PTR_W           = $clog2(DEPTH),
  localparam int CNT_W           = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  accum_wr_t        push_dat,
  input  logic             pop_rdy,
  output accum_wr_t        head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             prog_full
);
  accum_wr_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign prog_full = (count_q >= CNT_W'(DEPTH - PROG_FULL_MARGIN));
  assign count     = count_q;
  assign head_dat  = mem_q[rd_ptr_q];
  assign push_ok   = push_vld & ~full;
  assign pop_ok    = pop_rdy & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// File: rtl/accum_write_arbiter.sv
// Round-robin merge of NUM_REQ lane write streams onto the single accum_array port; min latency 2 (3 with ACCUM_COALESCE_EN).
// Lanes have no backpressure: each is buffered in a FIFO, drops when full set sticky overflow, req_full warns early.
module accum_write_arbiter
  import wordcount_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int FIFO_DEPTH       = 16,
  parameter int PROG_FULL_MARGIN = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*ACCUM_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*ACCUM_DATA_W-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_we,
  output logic [NUM_REQ-1:0]              req_full,
  output logic [NUM_REQ-1:0]              overflow,
  input  logic                            clear_overflow,
  output logic [ACCUM_ADDR_W-1:0]         accum_addr,
  output logic [ACCUM_DATA_W-1:0]         accum_din,
  output logic                            accum_we,
  output logic                            idle
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  accum_wr_t          lane_wr [NUM_REQ];
  accum_wr_t          head    [NUM_REQ];
  logic [CNT_W-1:0]   cnt     [NUM_REQ];
  logic [NUM_REQ-1:0] full, empty, pop, push_acc;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_wr[i] = {req_addr[ACCUM_ADDR_W*i +: ACCUM_ADDR_W], req_din[ACCUM_DATA_W*i +: ACCUM_DATA_W]};
    accum_lane_fifo #(
      .DEPTH            (FIFO_DEPTH),
      .PROG_FULL_MARGIN (PROG_FULL_MARGIN)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_vld  (req_we[i]),
      .push_dat  (lane_wr[i]),
      .pop_rdy   (pop[i]),
      .head_dat  (head[i]),
      .count     (cnt[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .prog_full (req_full[i])
    );
  end

  assign push_acc = req_we & ~full;

  logic [IDX_W-1:0]        rr_q, rr_d, grant_idx;
  logic [SUM_W-1:0]        lane_sum;
  logic                    grant_vld;
  accum_wr_t               grant_dat;
  logic [NUM_REQ-1:0]      ovf_q, ovf_d;
  logic                    we_q, we_d, idle_q, idle_d, all_empty_d;
  logic [ACCUM_ADDR_W-1:0] addr_q, addr_d;
  logic [ACCUM_DATA_W-1:0] din_q, din_d;

  // Scan downward so the lane closest to the pointer is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    lane_sum  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      lane_sum = {1'b0, rr_q} + SUM_W'(k);
      if (lane_sum >= SUM_W'(NUM_REQ)) lane_sum = lane_sum - SUM_W'(NUM_REQ);
      if (!empty[lane_sum[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = lane_sum[IDX_W-1:0];
      end
    end
    pop = '0;
    if (grant_vld) pop[grant_idx] = 1'b1;
    grant_dat = head[grant_idx];
    rr_d = rr_q;
    if (grant_vld) rr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Post-edge emptiness, so idle drops the cycle after a push lands.
  always_comb begin
    all_empty_d = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_acc[i] || (!empty[i] && !(pop[i] && cnt[i] == CNT_W'(1)))) all_empty_d = 1'b0;
    end
    ovf_d = (clear_overflow ? '0 : ovf_q) | (req_we & full);
  end

`ifdef ACCUM_COALESCE_EN
  localparam int MRG_W = $clog2(COALESCE_MAX + 1);
  accum_wr_t  pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic [MRG_W-1:0] mrg_q, mrg_d;

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    mrg_d      = mrg_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    if (grant_vld && pend_vld_q && grant_dat.addr == pend_q.addr && mrg_q < MRG_W'(COALESCE_MAX)) begin
      pend_d.din = pend_q.din + grant_dat.din;
      mrg_d      = mrg_q + MRG_W'(1);
    end else begin
      if (pend_vld_q) begin
        we_d   = 1'b1;
        addr_d = pend_q.addr;
        din_d  = pend_q.din;
      end
      pend_vld_d = grant_vld;
      if (grant_vld) pend_d = grant_dat;
      mrg_d = '0;
    end
    idle_d = all_empty_d && !we_d && !pend_vld_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mrg_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mrg_q      <= mrg_d;
    end
  end
`else
  always_comb begin
    we_d   = grant_vld;
    addr_d = grant_vld ? grant_dat.addr : addr_q;
    din_d  = grant_vld ? grant_dat.din  : din_q;
    idle_d = all_empty_d && !we_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q   <= '0;
      ovf_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      rr_q   <= rr_d;
      ovf_q  <= ovf_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      idle_q <= idle_d;
    end
  end

  assign overflow   = ovf_q;
  assign accum_we   = we_q;
  assign accum_addr = addr_q;
  assign accum_din  = din_q;
  assign idle       = idle_q;
endmodule

// File: tb/tb_accum_write_arbiter.sv
// Bench for accum_write_arbiter (default build): queue-based model checked every cycle plus directed literal checks.
module tb_accum_write_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*32-1:0] req_addr;
  logic [N*64-1:0] req_din;
  logic [N-1:0]   req_we;
  logic [N-1:0]   req_full;
  logic [N-1:0]   overflow;
  logic           clear_overflow;
  logic [31:0]    accum_addr;
  logic [63:0]    accum_din;
  logic           accum_we;
  logic           idle;

  accum_write_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH), .PROG_FULL_MARGIN(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_addr       (req_addr),
    .req_din        (req_din),
    .req_we         (req_we),
    .req_full       (req_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .accum_addr     (accum_addr),
    .accum_din      (accum_din),
    .accum_we       (accum_we),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [63:0] d; } ent_t;
  typedef struct { int cyc; logic [31:0] a; logic [63:0] d; } log_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: one queue per lane, round-robin pointer, registered outputs.
  ent_t        mq [N][$];
  int          m_rr   = 0;
  logic        m_we   = 1'b0;
  logic [31:0] m_addr = '0;
  logic [63:0] m_din  = '0;
  logic        m_idle = 1'b1;
  logic [N-1:0] m_ovf = '0;
  log_t        wlog [$];

  always @(posedge clk) begin
    int   g;
    int   sz [N];
    ent_t e;
    cyc++;
    if (!reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_we = 0; m_addr = '0; m_din = '0; m_ovf = '0; m_idle = 1; m_rr = 0;
    end else begin
      for (int i = 0; i < N; i++) sz[i] = mq[i].size();
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && sz[(m_rr + k) % N] > 0) g = (m_rr + k) % N;
      if (g >= 0) begin
        e = mq[g].pop_front();
        m_we = 1; m_addr = e.a; m_din = e.d; m_rr = (g + 1) % N;
      end else m_we = 0;
      if (clear_overflow) m_ovf = '0;
      for (int i = 0; i < N; i++) begin
        if (req_we[i]) begin
          if (sz[i] == DEPTH) m_ovf[i] = 1'b1;
          else mq[i].push_back('{a: req_addr[32*i +: 32], d: req_din[64*i +: 64]});
        end
      end
      m_idle = !m_we;
      for (int i = 0; i < N; i++) if (mq[i].size() != 0) m_idle = 0;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] m_full;
    for (int i = 0; i < N; i++) m_full[i] = (mq[i].size() >= DEPTH - 4);
    if (accum_we === 1'b1) wlog.push_back('{cyc: cyc, a: accum_addr, d: accum_din});
    if (chk_en) begin
      total++;
      if ({accum_we, accum_addr, accum_din, idle, overflow, req_full} !==
          {m_we, m_addr, m_din, m_idle, m_ovf, m_full}) begin
        bad++;
        $display("FAIL model_cycle cyc=%0d got we=%b addr=%h din=%h idle=%b ovf=%b full=%b want we=%b addr=%h din=%h idle=%b ovf=%b full=%b",
                 cyc, accum_we, accum_addr, accum_din, idle, overflow, req_full,
                 m_we, m_addr, m_din, m_idle, m_ovf, m_full);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_we = '0;
    reset  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [63:0] d);
    req_addr[32*l +: 32] = a;
    req_din[64*l +: 64]  = d;
  endtask

  task automatic wait_idle(input string name);
    for (int w = 0; w < 300 && idle !== 1'b1; w++) @(negedge clk);
    chk(name, idle, 1);
  endtask

  initial begin
    reset = 1'b0; req_we = '0; req_addr = '0; req_din = '0; clear_overflow = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    chk("rst_we", accum_we, 0);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_full", req_full, 0);

    // Single write on lane 2.
    set_lane(2, 32'h10, 64'd5);
    req_we = 4'b0100;
    @(negedge clk);
    req_we = '0;
    chk("sw_t1_we", accum_we, 0);
    chk("sw_t1_idle", idle, 0);
    @(negedge clk);
    chk("sw_t2_we", accum_we, 1);
    chk("sw_t2_addr", accum_addr, 32'h10);
    chk("sw_t2_din", accum_din, 64'd5);
    @(negedge clk);
    chk("sw_t3_we", accum_we, 0);
    chk("sw_t3_idle", idle, 1);
    chk("sw_t3_hold", accum_addr, 32'h10);

    // Fairness: all lanes push 3 entries.
    do_reset();
    wlog.delete();
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < N; l++) set_lane(l, 32'(l * 16 + k), 64'(100 * l + k));
      req_we = '1;
      @(negedge clk);
    end
    req_we = '0;
    repeat (16) @(negedge clk);
    chk("fair_count", wlog.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < wlog.size()) begin
        chk($sformatf("fair_ent%0d", k), {wlog[k].a, wlog[k].d}, {32'((k % 4) * 16 + k / 4), 64'(100 * (k % 4) + k / 4)});
        chk($sformatf("fair_gap%0d", k), wlog[k].cyc - wlog[0].cyc, k);
      end
    end

    // Backpressure: every lane pushes every cycle; lane 0 pops once per 4 cycles.
    do_reset();
    for (int n = 0; n < 22; n++) begin
      for (int l = 0; l < N; l++) set_lane(l, {8'(l), 24'(n)}, {$urandom, $urandom});
      req_we = '1;
      @(negedge clk);
      if (n == 14) chk("bp_full_pre", req_full[0], 0);
      if (n == 15) chk("bp_full_at12", req_full[0], 1);
      if (n == 20) chk("bp_ovf_pre", overflow[0], 0);
      if (n == 21) chk("bp_ovf_drop", overflow[0], 1);
    end
    req_we = '0;
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    chk("bp_ovf_clear", overflow, 0);
    wait_idle("bp_drain_idle");

    // Reset while entries are queued.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < N; l++) set_lane(l, 32'h100 + 32'(l), 64'(k));
      req_we = '1;
      @(negedge clk);
    end
    req_we = '0;
    reset  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_we", accum_we, 0);
    chk("mid_rst_idle", idle, 1);
    wlog.delete();
    repeat (10) @(negedge clk);
    chk("mid_rst_none", wlog.size(), 0);

    // Same-address run on lane 1 stays as separate writes.
    do_reset();
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      set_lane(1, (k < 3) ? 32'd7 : 32'd8, 64'(k + 1));
      req_we = 4'b0010;
      @(negedge clk);
    end
    req_we = '0;
    repeat (8) @(negedge clk);
    chk("co_count", wlog.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wlog.size())
        chk($sformatf("co_ent%0d", k), {wlog[k].a, wlog[k].d}, {(k < 3) ? 32'd7 : 32'd8, 64'(k + 1)});
    end
    wait_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d reached time limit", cyc);
    $fatal(1);
  end
endmodule
